// File: rtl/fb_arb_pkg.sv
// Shared types for the frame-buffer burst arbiter:
// FSM states, buffer index, grant owner and the triple-buffer rotation.
package fb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WR_BURST,
      RD_CMD,
      RD_DATA
   } state_t;

   typedef logic [1:0] buf_idx_t;

   typedef enum logic {
      WR,
      RD
   } grant_t;

   // The free buffer is the one neither side currently owns.
   function automatic buf_idx_t next_wr_buf(buf_idx_t w, buf_idx_t r);
      return 2'd3 - w - r;
   endfunction

endpackage

// File: rtl/fb_burst_arbiter_if.sv
// Avalon-MM burst master bundle between the arbiter and the SDRAM port.
// master = arbiter side, slave = SDRAM/HPS side.
interface fb_burst_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64
);
   logic [ADDR_W-1:0]   avm_address;
   logic [6:0]          avm_burstcount;
   logic                avm_write;
   logic [DATA_W-1:0]   avm_writedata;
   logic [DATA_W/8-1:0] avm_byteenable;
   logic                avm_read;
   logic                avm_waitrequest;
   logic [DATA_W-1:0]   avm_readdata;
   logic                avm_readdatavalid;

   modport master (
      output avm_address, avm_burstcount, avm_write,
      output avm_writedata, avm_byteenable, avm_read,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid
   );

   modport slave (
      input  avm_address, avm_burstcount, avm_write,
      input  avm_writedata, avm_byteenable, avm_read,
      output avm_waitrequest, avm_readdata, avm_readdatavalid
   );
endinterface

// File: rtl/fb_triple_buf_ctrl.sv
// Triple-buffer ownership: write buffer, read buffer and latest complete frame.
// A write completion is applied before a same-cycle read SOF.
module fb_triple_buf_ctrl
   import fb_arb_pkg::*;
(
   input  logic     clk,
   input  logic     reset_n,
   input  logic     wr_done_i,
   input  logic     rd_sof_i,
   output buf_idx_t wr_buf_o,
   output buf_idx_t rd_buf_o
);
   buf_idx_t wr_buf_q, wr_buf_d;
   buf_idx_t rd_buf_q, rd_buf_d;
   buf_idx_t latest_q, latest_d;

   always_comb begin
      wr_buf_d = wr_buf_q;
      rd_buf_d = rd_buf_q;
      latest_d = latest_q;
      if (wr_done_i) begin
         latest_d = wr_buf_q;
         wr_buf_d = next_wr_buf(wr_buf_q, rd_buf_q);
      end
      if (rd_sof_i) begin
         rd_buf_d = latest_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_buf_q <= 2'd0;
         rd_buf_q <= 2'd2;
         latest_q <= 2'd2;
      end else begin
         wr_buf_q <= wr_buf_d;
         rd_buf_q <= rd_buf_d;
         latest_q <= latest_d;
      end
   end

   assign wr_buf_o = wr_buf_q;
   assign rd_buf_o = rd_buf_q;
endmodule

// File: rtl/fb_burst_arbiter.sv
// Camera-write / display-read burst arbiter over one Avalon-MM SDRAM master.
// Define FB_ARB_RD_PRIORITY_EN to let reads always win a contested grant.
module fb_burst_arbiter
   import fb_arb_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DATA_W      = 64,
   parameter int unsigned       BURST_LEN   = 16,
   parameter int unsigned       FRAME_WORDS = 153600,
   parameter logic [ADDR_W-1:0] FB_BASE     = 32'h3000_0000,
   parameter int unsigned       LVL_W       = 9
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_sof,
   input  logic [LVL_W-1:0]  wr_fifo_level,
   input  logic [DATA_W-1:0] wr_fifo_q,
   output logic              wr_fifo_rdreq,
   input  logic              rd_sof,
   input  logic [LVL_W-1:0]  rd_fifo_space,
   output logic              rd_fifo_wrreq,
   output logic [DATA_W-1:0] rd_fifo_d,
   fb_burst_arbiter_if.master avm,
   output buf_idx_t          wr_buf,
   output buf_idx_t          rd_buf,
   output logic              frame_written
);
   localparam int unsigned OFF_W = $clog2(FRAME_WORDS + 1);
   localparam int unsigned BPW   = DATA_W / 8;
   localparam logic [ADDR_W-1:0] FRAME_BYTES = ADDR_W'(FRAME_WORDS * BPW);

   if ((FRAME_WORDS % BURST_LEN) != 0) begin : g_bad_frame
      $error("FRAME_WORDS must be a multiple of BURST_LEN");
   end
   if (BURST_LEN > 64 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_burst
      $error("BURST_LEN must be a power of two no larger than 64");
   end

   state_t           state_q, state_d;
   grant_t           last_q, last_d, both_gnt, gnt;
   logic [6:0]       beat_q, beat_d;
   logic [OFF_W-1:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d;
   logic             wr_active_q, wr_active_d, rd_active_q, rd_active_d;
   logic             wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
   logic             fw_q;
   logic             wr_elig, rd_elig, wr_busy, rd_busy;
   logic             wr_beat, rd_beat, wr_last, rd_last;
   logic             wr_done, rd_done, wr_sof_go, rd_sof_go;

   function automatic logic [ADDR_W-1:0] buf_addr(buf_idx_t b, logic [OFF_W-1:0] off);
      return FB_BASE + ADDR_W'(b) * FRAME_BYTES + ADDR_W'(off) * ADDR_W'(BPW);
   endfunction

   assign wr_elig = wr_active_q && (wr_fifo_level >= LVL_W'(BURST_LEN));
   assign rd_elig = rd_active_q && (rd_fifo_space >= LVL_W'(BURST_LEN));
   assign wr_busy = (state_q == WR_BURST);
   assign rd_busy = (state_q == RD_CMD) || (state_q == RD_DATA);
   assign wr_beat = wr_busy && !avm.avm_waitrequest;
   assign rd_beat = (state_q == RD_DATA) && avm.avm_readdatavalid;
   assign wr_last = wr_beat && (beat_q == 7'(BURST_LEN - 1));
   assign rd_last = rd_beat && (beat_q == 7'(BURST_LEN - 1));
   assign wr_done = wr_last && ((wr_off_q + OFF_W'(BURST_LEN)) == OFF_W'(FRAME_WORDS));
   assign rd_done = rd_last && ((rd_off_q + OFF_W'(BURST_LEN)) == OFF_W'(FRAME_WORDS));

   // SOF in the direction of the running burst waits for that burst to end.
   assign wr_sof_go = (wr_sof || wr_pend_q) && (!wr_busy || wr_last);
   assign rd_sof_go = (rd_sof || rd_pend_q) && (!rd_busy || rd_last);
   assign wr_pend_d = (wr_sof || wr_pend_q) && !wr_sof_go;
   assign rd_pend_d = (rd_sof || rd_pend_q) && !rd_sof_go;

`ifdef FB_ARB_RD_PRIORITY_EN
   assign both_gnt = RD;
`else
   assign both_gnt = (last_q == RD) ? WR : RD;
`endif

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      beat_d  = beat_q;
      gnt     = RD;
      unique case (state_q)
         IDLE: begin
            if (wr_elig && rd_elig) gnt = both_gnt;
            else if (wr_elig)       gnt = WR;
            if (wr_elig || rd_elig) begin
               last_d  = gnt;
               beat_d  = '0;
               state_d = (gnt == WR) ? WR_BURST : RD_CMD;
            end
         end
         WR_BURST: begin
            if (wr_beat) beat_d = beat_q + 7'd1;
            if (wr_last) begin
               beat_d  = '0;
               state_d = IDLE;
            end
         end
         RD_CMD: begin
            if (!avm.avm_waitrequest) state_d = RD_DATA;
         end
         RD_DATA: begin
            if (rd_beat) beat_d = beat_q + 7'd1;
            if (rd_last) begin
               beat_d  = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_off_d    = wr_off_q;
      rd_off_d    = rd_off_q;
      wr_active_d = wr_active_q;
      rd_active_d = rd_active_q;
      if (wr_last) wr_off_d = wr_off_q + OFF_W'(BURST_LEN);
      if (wr_done) wr_active_d = 1'b0;
      if (wr_sof_go) begin
         wr_off_d    = '0;
         wr_active_d = 1'b1;
      end
      if (rd_last) rd_off_d = rd_off_q + OFF_W'(BURST_LEN);
      if (rd_done) rd_active_d = 1'b0;
      if (rd_sof_go) begin
         rd_off_d    = '0;
         rd_active_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         last_q      <= RD;
         beat_q      <= '0;
         wr_off_q    <= '0;
         rd_off_q    <= '0;
         wr_active_q <= 1'b0;
         rd_active_q <= 1'b0;
         wr_pend_q   <= 1'b0;
         rd_pend_q   <= 1'b0;
         fw_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         beat_q      <= beat_d;
         wr_off_q    <= wr_off_d;
         rd_off_q    <= rd_off_d;
         wr_active_q <= wr_active_d;
         rd_active_q <= rd_active_d;
         wr_pend_q   <= wr_pend_d;
         rd_pend_q   <= rd_pend_d;
         fw_q        <= wr_done;
      end
   end

   fb_triple_buf_ctrl u_tbuf (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_done_i (wr_done),
      .rd_sof_i  (rd_sof_go),
      .wr_buf_o  (wr_buf),
      .rd_buf_o  (rd_buf)
   );

   assign avm.avm_write      = wr_busy;
   assign avm.avm_read       = (state_q == RD_CMD);
   assign avm.avm_address    = wr_busy ? buf_addr(wr_buf, wr_off_q) :
                               avm.avm_read ? buf_addr(rd_buf, rd_off_q) : '0;
   assign avm.avm_burstcount = (wr_busy || avm.avm_read) ? 7'(BURST_LEN) : 7'd0;
   assign avm.avm_writedata  = wr_busy ? wr_fifo_q : '0;
   assign avm.avm_byteenable = '1;
   assign wr_fifo_rdreq      = wr_beat;
   assign rd_fifo_wrreq      = rd_beat;
   assign rd_fifo_d          = rd_beat ? avm.avm_readdata : '0;
   assign frame_written      = fw_q;
endmodule

// File: tb/tb_fb_burst_arbiter.sv
// Directed/randomised bench for fb_burst_arbiter with an SDRAM and FIFO model.
// Small frame (64 words) so whole frames rotate through all three buffers.
module tb_fb_burst_arbiter;
   import fb_arb_pkg::*;

   localparam int          BL   = 16;
   localparam int          FW   = 64;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        wr_sof = 1'b0;
   logic        rd_sof = 1'b0;
   logic [8:0]  wr_fifo_level;
   logic [8:0]  rd_fifo_space = 9'd0;
   logic [63:0] wr_fifo_q, rd_fifo_d;
   logic        wr_fifo_rdreq, rd_fifo_wrreq, frame_written;
   buf_idx_t    wr_buf, rd_buf;

   fb_burst_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

   fb_burst_arbiter #(
      .ADDR_W(32), .DATA_W(64), .BURST_LEN(BL), .FRAME_WORDS(FW),
      .FB_BASE(BASE), .LVL_W(9)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .wr_sof(wr_sof), .wr_fifo_level(wr_fifo_level), .wr_fifo_q(wr_fifo_q),
      .wr_fifo_rdreq(wr_fifo_rdreq),
      .rd_sof(rd_sof), .rd_fifo_space(rd_fifo_space),
      .rd_fifo_wrreq(rd_fifo_wrreq), .rd_fifo_d(rd_fifo_d),
      .avm(bus),
      .wr_buf(wr_buf), .rd_buf(rd_buf), .frame_written(frame_written)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // camera FIFO model (show-ahead)
   logic [63:0] cam_mem [256];
   int cam_head = 0;
   int cam_tail = 0;
   assign wr_fifo_level = 9'(cam_tail - cam_head);
   assign wr_fifo_q     = cam_mem[cam_head[7:0]];
   always @(posedge clk) if (wr_fifo_rdreq) cam_head <= cam_head + 1;

   // SDRAM model: 3 buffers of 64 words, word index = (addr-BASE)/8
   logic [63:0] mem [256];
   logic [31:0] wr_log[$];
   logic [31:0] rd_log[$];
   bit          gnt_log[$];
   int          wbeat = 0;
   int          rleft = 0;
   logic [7:0]  ridx = 8'd0;
   bit          force_wait = 1'b0;
   bit          rand_wait = 1'b0;

   always @(negedge clk)
      bus.avm_waitrequest <= force_wait || (rand_wait && $urandom_range(2) == 0);

   always @(posedge clk) begin
      if (!reset_n) wbeat <= 0;
      else if (bus.avm_write && !bus.avm_waitrequest) begin
         mem[8'((bus.avm_address - BASE) >> 3) + 8'(wbeat)] <= bus.avm_writedata;
         if (wbeat == 0) begin
            wr_log.push_back(bus.avm_address);
            gnt_log.push_back(1'b0);
         end
         wbeat <= (wbeat == BL - 1) ? 0 : wbeat + 1;
      end
   end

   always @(posedge clk) begin
      if (!reset_n) begin
         rleft <= 0;
         bus.avm_readdatavalid <= 1'b0;
         bus.avm_readdata <= '0;
      end else begin
         bus.avm_readdatavalid <= 1'b0;
         if (rleft > 0) begin
            if ($urandom_range(3) != 0) begin
               bus.avm_readdatavalid <= 1'b1;
               bus.avm_readdata <= mem[ridx];
               ridx  <= ridx + 8'd1;
               rleft <= rleft - 1;
            end
         end else if (bus.avm_read && !bus.avm_waitrequest) begin
            rleft <= BL;
            ridx  <= 8'((bus.avm_address - BASE) >> 3);
            rd_log.push_back(bus.avm_address);
            gnt_log.push_back(1'b1);
         end
      end
   end

   // display FIFO capture and frame pulse counter
   logic [63:0] disp_d [256];
   int disp_cnt = 0;
   int fw_cnt = 0;
   always @(posedge clk) begin
      if (rd_fifo_wrreq) begin
         disp_d[disp_cnt[7:0]] <= rd_fifo_d;
         disp_cnt <= disp_cnt + 1;
      end
      if (frame_written) fw_cnt <= fw_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) begin
         cam_mem[cam_tail[7:0]] = {$urandom(), $urandom()};
         cam_tail++;
      end
   endtask

   function automatic logic [31:0] baddr(input int b, input int off);
      return BASE + 32'(b * FW * 8) + 32'(off * 8);
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int f0, f1, f2, f3, p0, p1;
      int wl, rl;
      bit last, g;
      bit exp_g[$];

      repeat (3) tick();
      chk("rst_wr_buf", 64'(wr_buf), 64'(0));
      chk("rst_rd_buf", 64'(rd_buf), 64'(2));
      chk("rst_fw", 64'(frame_written), 64'(0));
      chk("rst_write", 64'(bus.avm_write), 64'(0));
      chk("rst_read", 64'(bus.avm_read), 64'(0));
      chk("rst_be", 64'(bus.avm_byteenable), 64'hFF);
      chk("rst_addr", 64'(bus.avm_address), 64'(0));
      chk("rst_bc", 64'(bus.avm_burstcount), 64'(0));
      chk("rst_rdreq", 64'(wr_fifo_rdreq), 64'(0));
      chk("rst_wrreq", 64'(rd_fifo_wrreq), 64'(0));
      reset_n = 1'b1;
      tick();

      // frame 0 into buffer 0 with random waitrequest
      rand_wait = 1'b1;
      f0 = cam_tail;
      push(FW);
      wr_sof = 1'b1; tick(); wr_sof = 1'b0;
      for (int i = 0; i < 3000 && fw_cnt < 1; i++) tick();
      repeat (3) tick();
      chk("f0_fw_cnt", 64'(fw_cnt), 64'(1));
      chk("f0_wr_buf", 64'(wr_buf), 64'(1));
      chk("f0_rd_buf", 64'(rd_buf), 64'(2));
      chk("f0_pops", 64'(cam_head - f0), 64'(FW));
      chk("f0_nbursts", 64'(wr_log.size()), 64'(4));
      for (int k = 0; k < 4 && k < wr_log.size(); k++)
         chk("f0_waddr", 64'(wr_log[k]), 64'(baddr(0, k * BL)));
      for (int k = 0; k < FW; k++)
         chk("f0_mem", mem[k], cam_mem[8'(f0 + k)]);

      // read frame 0, only once the display FIFO has room for a burst
      rd_fifo_space = 9'd15;
      rd_sof = 1'b1; tick(); rd_sof = 1'b0;
      chk("r0_rd_buf", 64'(rd_buf), 64'(0));
      repeat (20) tick();
      chk("r0_no_read", 64'(rd_log.size()), 64'(0));
      rd_fifo_space = 9'd16;
      for (int i = 0; i < 3000 && disp_cnt < FW; i++) tick();
      repeat (10) tick();
      chk("r0_beats", 64'(disp_cnt), 64'(FW));
      chk("r0_nbursts", 64'(rd_log.size()), 64'(4));
      for (int k = 0; k < 4 && k < rd_log.size(); k++)
         chk("r0_raddr", 64'(rd_log[k]), 64'(baddr(0, k * BL)));
      for (int k = 0; k < FW; k++)
         chk("r0_data", disp_d[k], cam_mem[8'(f0 + k)]);

      // both requesters eligible: frame 1 into buffer 1 while re-reading buffer 0
      gnt_log.delete(); wr_log.delete(); rd_log.delete();
      f1 = cam_tail;
      push(FW);
      wr_sof = 1'b1; rd_sof = 1'b1; tick(); wr_sof = 1'b0; rd_sof = 1'b0;
      chk("c_rd_buf", 64'(rd_buf), 64'(0));
      for (int i = 0; i < 6000 && !(fw_cnt == 2 && disp_cnt == 2 * FW); i++) tick();
      repeat (10) tick();
      wl = 4; rl = 4; last = 1'b1;
      while (wl > 0 || rl > 0) begin
`ifdef FB_ARB_RD_PRIORITY_EN
         if (wl > 0 && rl > 0) g = 1'b1;
`else
         if (wl > 0 && rl > 0) g = !last;
`endif
         else g = (rl > 0);
         exp_g.push_back(g);
         last = g;
         if (g) rl--; else wl--;
      end
      chk("c_ngrants", 64'(gnt_log.size()), 64'(8));
      for (int k = 0; k < 8 && k < gnt_log.size(); k++)
         chk("c_grant", 64'(gnt_log[k]), 64'(exp_g[k]));
      chk("c_wr_buf", 64'(wr_buf), 64'(2));
      chk("c_rd_buf2", 64'(rd_buf), 64'(0));
      chk("c_fw_cnt", 64'(fw_cnt), 64'(2));
      for (int k = 0; k < 4 && k < wr_log.size(); k++)
         chk("c_waddr", 64'(wr_log[k]), 64'(baddr(1, k * BL)));
      for (int k = 0; k < FW; k++) begin
         chk("c_rdata", disp_d[8'(FW + k)], cam_mem[8'(f0 + k)]);
         chk("c_mem", mem[8'(FW + k)], cam_mem[8'(f1 + k)]);
      end

      // waitrequest stall mid write burst into buffer 2
      rand_wait = 1'b0;
      wr_log.delete();
      f2 = cam_tail;
      p0 = cam_head;
      push(BL);
      wr_sof = 1'b1; tick(); wr_sof = 1'b0;
      for (int i = 0; i < 200 && (cam_head - p0) < 8; i++) tick();
      force_wait = 1'b1;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk); #1;
         chk("st_addr", 64'(bus.avm_address), 64'(baddr(2, 0)));
         chk("st_bc", 64'(bus.avm_burstcount), 64'(BL));
         chk("st_wdata", bus.avm_writedata, cam_mem[8'(f2 + 8)]);
         chk("st_rdreq", 64'(wr_fifo_rdreq), 64'(0));
      end
      chk("st_pops_held", 64'(cam_head - p0), 64'(8));
      force_wait = 1'b0;
      for (int i = 0; i < 200 && (cam_head - p0) < BL; i++) tick();
      repeat (3) tick();
      chk("st_pops", 64'(cam_head - p0), 64'(BL));
      chk("st_fw_cnt", 64'(fw_cnt), 64'(2));

      // wr_sof during the 2nd burst restarts the frame in the same buffer
      f3 = cam_tail;
      push(2 * BL);
      for (int i = 0; i < 200 && (cam_head - p0) < BL + 4; i++) tick();
      wr_sof = 1'b1; tick(); wr_sof = 1'b0;
      for (int i = 0; i < 300 && (cam_head - p0) < 3 * BL; i++) tick();
      repeat (3) tick();
      chk("ms_nbursts", 64'(wr_log.size()), 64'(3));
      if (wr_log.size() == 3) begin
         chk("ms_addr0", 64'(wr_log[0]), 64'(baddr(2, 0)));
         chk("ms_addr1", 64'(wr_log[1]), 64'(baddr(2, BL)));
         chk("ms_addr2", 64'(wr_log[2]), 64'(baddr(2, 0)));
      end
      chk("ms_fw_cnt", 64'(fw_cnt), 64'(2));
      chk("ms_wr_buf", 64'(wr_buf), 64'(2));
      for (int k = 0; k < BL; k++) begin
         chk("ms_mem_lo", mem[8'(2 * FW + k)], cam_mem[8'(f3 + BL + k)]);
         chk("ms_mem_hi", mem[8'(2 * FW + BL + k)], cam_mem[8'(f3 + k)]);
      end

      // finish buffer 2 with rd_sof on the completing beat (w=2, r=0, latest=1)
      rd_fifo_space = 9'd0;
      p1 = cam_head;
      push(FW - BL);
      for (int i = 0; i < 400 && (cam_head - p1) < FW - BL - 1; i++) tick();
      rd_sof = 1'b1; tick(); rd_sof = 1'b0;
      chk("sc1_fw", 64'(frame_written), 64'(1));
      chk("sc1_wr_buf", 64'(wr_buf), 64'(1));
      chk("sc1_rd_buf", 64'(rd_buf), 64'(2));
      tick();
      chk("sc1_fw_pulse", 64'(frame_written), 64'(0));

      // next frame with w=1, r=2: completion plus rd_sof gives latest=1, r=1, w=0
      p1 = cam_head;
      push(FW);
      wr_sof = 1'b1; tick(); wr_sof = 1'b0;
      for (int i = 0; i < 400 && (cam_head - p1) < FW - 1; i++) tick();
      rd_sof = 1'b1; tick(); rd_sof = 1'b0;
      chk("sc2_fw", 64'(frame_written), 64'(1));
      chk("sc2_wr_buf", 64'(wr_buf), 64'(0));
      chk("sc2_rd_buf", 64'(rd_buf), 64'(1));
      repeat (3) tick();
      chk("end_fw_cnt", 64'(fw_cnt), 64'(4));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
